// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / command-out handshake bundle for uart_cmd_ctrl.
// The slave modport is the controller's view; the master modport is the view of the receiver and consumer side.
`timescale 1ns/1ps

interface uart_cmd_ctrl_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_vld;
    logic        cmd_ack;
    logic        frame_err;
    logic        busy;

    modport slave (
        input  rx_rdy, rx_data, cmd_ack,
        output clr_rx_rdy, cmd, cmd_vld, frame_err, busy
    );

    modport master (
        output rx_rdy, rx_data, cmd_ack,
        input  clr_rx_rdy, cmd, cmd_vld, frame_err, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Assembles 1-byte (opcode[7]=1) or 3-byte commands from a UART byte stream.
// An inter-byte timeout discards a partial command and pulses frame_err.
`timescale 1ns/1ps

module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_ctrl_if.slave bus
);
    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GET1 = 2'd1,
        GET2 = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       byte1_q, byte1_d;
    logic [23:0]      cmd_q, cmd_d;
    logic             cmd_vld_q, cmd_vld_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        opcode_d    = opcode_q;
        byte1_d     = byte1_q;
        cmd_d       = cmd_q;
        cmd_vld_d   = cmd_vld_q;
        frame_err_d = 1'b0;
        cnt_d       = '0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                accept = bus.rx_rdy;
                if (accept) begin
                    if (bus.rx_data[7]) begin
                        cmd_d     = {bus.rx_data, 16'h0000};
                        cmd_vld_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        opcode_d = bus.rx_data;
                        state_d  = GET1;
                    end
                end
            end

            GET1, GET2: begin
                accept = bus.rx_rdy;
                if (accept) begin
                    if (state_q == GET1) begin
                        byte1_d = bus.rx_data;
                        state_d = GET2;
                    end else begin
                        cmd_d     = {opcode_q, byte1_q, bus.rx_data};
                        cmd_vld_d = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Counter never passes CNT_LAST: the timeout exits before a wrap.
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    opcode_d    = '0;
                    byte1_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HOLD: begin
                if (bus.cmd_ack) begin
                    cmd_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                opcode_d  = '0;
                byte1_d   = '0;
                cmd_d     = '0;
                cmd_vld_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            byte1_q     <= '0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            byte1_q     <= byte1_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Gating with rst_n stops a held rx_rdy from being knocked down while in reset.
    assign bus.clr_rx_rdy = accept & rst_n;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_vld    = cmd_vld_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
